// File: rtl/multi_player_controller.sv
// Player movement and bomb placement controller for NUM_PLAYERS players on a
// 2^GW x 2^GW grid. Requests are captured for one cycle, then resolved against
// grid edges, walls and other players. Accepted bombs are published on a
// periodic commit strobe.
module multi_player_controller #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned GW            = 4,
  parameter int unsigned BW            = 3,
  parameter int unsigned STEP_INTERVAL = 0,
  parameter int unsigned COMMIT_PERIOD = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PLAYERS-1:0]      in_valid_i,
  input  logic [3*NUM_PLAYERS-1:0]    dir_i,
  input  logic [NUM_PLAYERS-1:0]      bomb_req_i,
  input  logic [NUM_PLAYERS-1:0]      alive_i,
  input  logic [2**(2*GW)-1:0]        wall_i,
  input  logic [BW*NUM_PLAYERS-1:0]   bomb_num_i,
  input  logic [BW*NUM_PLAYERS-1:0]   bomb_max_i,
  output logic [GW*NUM_PLAYERS-1:0]   pos_x_o,
  output logic [GW*NUM_PLAYERS-1:0]   pos_y_o,
  output logic [2*GW*NUM_PLAYERS-1:0] coord_o,
  output logic [2*NUM_PLAYERS-1:0]    face_o,
  output logic [NUM_PLAYERS-1:0]      moved_o,
  output logic                        commit_o,
  output logic [NUM_PLAYERS-1:0]      set_bomb_o,
  output logic [2*GW*NUM_PLAYERS-1:0] bomb_coord_o
);
  localparam int unsigned N    = NUM_PLAYERS;
  localparam int unsigned CDW  = (STEP_INTERVAL > 0) ? $clog2(STEP_INTERVAL + 1) : 1;
  localparam int unsigned CNTW = $clog2(COMMIT_PERIOD);
  localparam logic [GW-1:0]   MAXC     = {GW{1'b1}};
  localparam logic [GW-1:0]   ONE      = GW'(1);
  localparam logic [CDW-1:0]  CD_LOAD  = CDW'(STEP_INTERVAL);
  localparam logic [CDW-1:0]  CD_ONE   = CDW'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(COMMIT_PERIOD - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [N-1:0]    r_cap_vld;
  logic [2:0]      r_cap_dir [N];
  logic [N-1:0]    r_cap_bomb;
  logic [GW-1:0]   r_px [N];
  logic [GW-1:0]   r_py [N];
  logic [1:0]      r_face [N];
  logic [CDW-1:0]  r_cd [N];
  logic [N-1:0]    r_moved;
  logic [N-1:0]    r_pend;
  logic [2*GW-1:0] r_bcell [N];
  logic [N-1:0]    r_set_bomb;
  logic [2*GW-1:0] r_bcoord [N];
  logic [CNTW-1:0] r_cnt;

  logic [N-1:0]    w_act;
  logic [N-1:0]    w_dir_ok;
  logic [N-1:0]    w_in_grid;
  logic [N-1:0]    w_acc;
  logic [N-1:0]    w_bomb_acc;
  logic [GW-1:0]   w_tx [N];
  logic [GW-1:0]   w_ty [N];
  logic            w_publish;

  assign w_publish = (r_cnt == CNT_LAST);
  assign commit_o  = w_publish;

  // Capture stage: one-cycle valid flag, payload held only on a new strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_vld  <= '0;
      r_cap_bomb <= '0;
      for (int i = 0; i < N; i++) r_cap_dir[i] <= 3'd0;
    end else begin
      r_cap_vld <= in_valid_i;
      for (int i = 0; i < N; i++) begin
        if (in_valid_i[i]) begin
          r_cap_dir[i]  <= dir_i[3*i +: 3];
          r_cap_bomb[i] <= bomb_req_i[i];
        end
      end
    end
  end

  // Target cell per player; UP/LEFT decrement, DOWN/RIGHT increment, no wrap
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_act[i]     = r_cap_vld[i] & alive_i[i];
      w_tx[i]      = r_px[i];
      w_ty[i]      = r_py[i];
      w_dir_ok[i]  = 1'b0;
      w_in_grid[i] = 1'b0;
      case (r_cap_dir[i])
        3'd0: begin
          w_dir_ok[i] = 1'b1; w_in_grid[i] = (r_py[i] != '0);   w_ty[i] = r_py[i] - ONE;
        end
        3'd1: begin
          w_dir_ok[i] = 1'b1; w_in_grid[i] = (r_py[i] != MAXC); w_ty[i] = r_py[i] + ONE;
        end
        3'd2: begin
          w_dir_ok[i] = 1'b1; w_in_grid[i] = (r_px[i] != '0);   w_tx[i] = r_px[i] - ONE;
        end
        3'd3: begin
          w_dir_ok[i] = 1'b1; w_in_grid[i] = (r_px[i] != MAXC); w_tx[i] = r_px[i] + ONE;
        end
        default: ;
      endcase
    end
  end

  // Move and bomb acceptance; lower-index players win contested targets
  always_comb begin
    logic [N-1:0] acc;
    acc        = '0;
    w_bomb_acc = '0;
    for (int i = 0; i < N; i++) begin
      acc[i] = w_act[i] & w_dir_ok[i] & w_in_grid[i] & (r_cd[i] == '0) &
               ~wall_i[{w_ty[i], w_tx[i]}];
      for (int j = 0; j < N; j++) begin
        if (j != i && w_tx[i] == r_px[j] && w_ty[i] == r_py[j]) acc[i] = 1'b0;
        if (j < i && acc[j] && w_tx[i] == w_tx[j] && w_ty[i] == w_ty[j]) acc[i] = 1'b0;
      end
      w_bomb_acc[i] = w_act[i] & r_cap_bomb[i] & ~r_pend[i] &
                      (bomb_num_i[i*BW +: BW] < bomb_max_i[i*BW +: BW]);
    end
    w_acc = acc;
  end

  // Commit counter: free-running modulo COMMIT_PERIOD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (w_publish) r_cnt <= '0;
    else r_cnt <= r_cnt + CNT_ONE;
  end

  // Player state: position, facing, cooldown, pending bomb and publish pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_moved    <= '0;
      r_pend     <= '0;
      r_set_bomb <= '0;
      for (int i = 0; i < N; i++) begin
        r_px[i]     <= (i == 1 || i == 2) ? MAXC : '0;
        r_py[i]     <= (i == 1 || i == 3) ? MAXC : '0;
        r_face[i]   <= 2'd0;
        r_cd[i]     <= '0;
        r_bcell[i]  <= '0;
        r_bcoord[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_moved[i]    <= w_acc[i];
        r_set_bomb[i] <= 1'b0;
        if (w_act[i] && w_dir_ok[i]) r_face[i] <= r_cap_dir[i][1:0];
        if (w_acc[i]) begin
          r_px[i] <= w_tx[i];
          r_py[i] <= w_ty[i];
          r_cd[i] <= CD_LOAD;
        end else if (r_cd[i] != '0) begin
          r_cd[i] <= r_cd[i] - CD_ONE;
        end
        // A dead player's pending bomb is dropped; publish takes priority over a
        // new request, which is only possible when nothing is pending
        if (!alive_i[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_publish && r_pend[i]) begin
          r_set_bomb[i] <= 1'b1;
          r_bcoord[i]   <= r_bcell[i];
          r_pend[i]     <= 1'b0;
        end else if (w_bomb_acc[i]) begin
          r_pend[i]  <= 1'b1;
          r_bcell[i] <= {r_py[i], r_px[i]};
        end
      end
    end
  end

  // Output packing
  always_comb begin
    pos_x_o      = '0;
    pos_y_o      = '0;
    coord_o      = '0;
    face_o       = '0;
    bomb_coord_o = '0;
    for (int i = 0; i < N; i++) begin
      pos_x_o[i*GW +: GW]          = r_px[i];
      pos_y_o[i*GW +: GW]          = r_py[i];
      coord_o[i*2*GW +: 2*GW]      = {r_py[i], r_px[i]};
      face_o[i*2 +: 2]             = r_face[i];
      bomb_coord_o[i*2*GW +: 2*GW] = r_bcoord[i];
    end
  end

  assign moved_o    = r_moved;
  assign set_bomb_o = r_set_bomb;

endmodule

// File: tb/tb_multi_player_controller.sv
// Directed bench for multi_player_controller: a default instance plus one with a
// three-cycle move cooldown, both driven by the same stimulus.
module tb_multi_player_controller;
  localparam int N = 2, GW = 4, BW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]      in_valid, bomb_req, alive;
  logic [3*N-1:0]    dir;
  logic [255:0]      wall;
  logic [BW*N-1:0]   bomb_num, bomb_max;

  logic [GW*N-1:0]   pos_x, pos_y, cd_pos_x, cd_pos_y;
  logic [2*GW*N-1:0] coord, bcoord, cd_coord, cd_bcoord;
  logic [2*N-1:0]    face, cd_face;
  logic [N-1:0]      moved, set_bomb, cd_moved, cd_set_bomb;
  logic              commit, cd_commit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_player_controller #(.NUM_PLAYERS(N), .GW(GW), .BW(BW), .STEP_INTERVAL(0),
                            .COMMIT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .dir_i(dir), .bomb_req_i(bomb_req),
    .alive_i(alive), .wall_i(wall), .bomb_num_i(bomb_num), .bomb_max_i(bomb_max),
    .pos_x_o(pos_x), .pos_y_o(pos_y), .coord_o(coord), .face_o(face), .moved_o(moved),
    .commit_o(commit), .set_bomb_o(set_bomb), .bomb_coord_o(bcoord)
  );

  multi_player_controller #(.NUM_PLAYERS(N), .GW(GW), .BW(BW), .STEP_INTERVAL(3),
                            .COMMIT_PERIOD(5)) u_cd (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .dir_i(dir), .bomb_req_i(bomb_req),
    .alive_i(alive), .wall_i(wall), .bomb_num_i(bomb_num), .bomb_max_i(bomb_max),
    .pos_x_o(cd_pos_x), .pos_y_o(cd_pos_y), .coord_o(cd_coord), .face_o(cd_face),
    .moved_o(cd_moved), .commit_o(cd_commit), .set_bomb_o(cd_set_bomb),
    .bomb_coord_o(cd_bcoord)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic [1:0] v, input logic [2:0] d0, input logic [2:0] d1,
                     input logic [1:0] b);
    in_valid = v;
    dir      = {d1, d0};
    bomb_req = b;
  endtask

  // Leaves the bench 1 time unit after a posedge, in cycle 0 after release
  task automatic do_reset();
    rst      = 1'b0;
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    wall     = '0;
    alive    = 2'b11;
    bomb_num = '0;
    bomb_max = {3'd2, 3'd2};
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state and free move
    do_reset();
    chk("rst_p0", coord[7:0], 32'h00);
    chk("rst_p1", coord[15:8], 32'hff);
    chk("rst_face", face, 0);
    chk("rst_moved", moved, 0);
    chk("rst_commit", commit, 0);
    chk("rst_setb", set_bomb, 0);
    chk("rst_bcoord", bcoord, 0);
    drv(2'b01, 3'd3, 3'd4, 2'b00);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    chk("fm_c1_x", pos_x[3:0], 0);
    tick();
    chk("fm_x", pos_x[3:0], 1);
    chk("fm_moved", moved, 2'b01);
    chk("fm_face", face[1:0], 3);
    tick();
    chk("fm_moved_off", moved, 0);
    chk("cm_c3", commit, 0);
    tick();
    chk("cm_c4", commit, 1);
    tick();
    chk("cm_c5", commit, 0);

    // Edge block: UP then LEFT from (0,0)
    do_reset();
    drv(2'b01, 3'd0, 3'd4, 2'b00);
    tick();
    drv(2'b01, 3'd2, 3'd4, 2'b00);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    chk("eb_face_up", face[1:0], 0);
    chk("eb_pos1", coord[7:0], 0);
    chk("eb_moved1", moved, 0);
    tick();
    chk("eb_face_left", face[1:0], 2);
    chk("eb_pos2", coord[7:0], 0);
    chk("eb_moved2", moved, 0);

    // Walk P0 to (3,4) and P1 to (5,4), then contend for (4,4)
    do_reset();
    for (int k = 0; k < 21; k++) begin
      drv({1'b1, (k < 7)}, (k < 3) ? 3'd3 : 3'd1, (k < 10) ? 3'd2 : 3'd0, 2'b00);
      tick();
    end
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick(2);
    chk("ct_p0_pre", coord[7:0], 32'h43);
    chk("ct_p1_pre", coord[15:8], 32'h45);
    drv(2'b11, 3'd3, 3'd2, 2'b00);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick();
    chk("ct_p0", coord[7:0], 32'h44);
    chk("ct_p1", coord[15:8], 32'h45);
    chk("ct_moved", moved, 2'b01);
    chk("ct_face", face, 4'b1011);
    // Wall below P0, then P1 occupies the cell to its right
    wall[5*16+4] = 1'b1;
    drv(2'b01, 3'd1, 3'd4, 2'b00);
    tick();
    drv(2'b01, 3'd3, 3'd4, 2'b00);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    chk("wl_face", face[1:0], 1);
    chk("wl_pos", coord[7:0], 32'h44);
    chk("wl_moved", moved, 0);
    tick();
    chk("oc_face", face[1:0], 3);
    chk("oc_pos", coord[7:0], 32'h44);
    chk("oc_moved", moved, 0);
    // Dead player ignores requests
    alive = 2'b01;
    drv(2'b10, 3'd4, 3'd0, 2'b00);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick();
    chk("dead_pos", coord[15:8], 32'h45);
    chk("dead_face", face[3:2], 2);
    chk("dead_moved", moved, 0);

    // Bomb gating
    do_reset();
    bomb_num = {3'd1, 3'd1};
    drv(2'b01, 3'd4, 3'd4, 2'b01);
    tick();
    drv(2'b01, 3'd4, 3'd4, 2'b01);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick(2);
    chk("bm_commit", commit, 1);
    chk("bm_pre", set_bomb, 0);
    tick();
    chk("bm_pulse", set_bomb, 2'b01);
    chk("bm_coord", bcoord[7:0], 0);
    tick();
    chk("bm_single", set_bomb, 0);
    drv(2'b01, 3'd3, 3'd4, 2'b00);
    tick();
    drv(2'b01, 3'd1, 3'd4, 2'b01);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick();
    chk("bm2_pos", coord[7:0], 32'h11);
    chk("bm2_commit", commit, 1);
    chk("bm2_pre", set_bomb, 0);
    tick();
    chk("bm2_pulse", set_bomb, 2'b01);
    chk("bm2_coord", bcoord[7:0], 32'h01);
    bomb_num = {3'd1, 3'd2};
    drv(2'b01, 3'd4, 3'd4, 2'b01);
    tick();
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick(3);
    chk("bm3_commit", commit, 1);
    tick();
    chk("bm3_full", set_bomb, 0);

    // Cooldown of 3: moves visible in cycles 2, 6, 10, 14; cycle-2 DOWN only turns
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drv(2'b01, (c == 2) ? 3'd1 : 3'd3, 3'd4, 2'b00);
      tick();
      chk($sformatf("cd_x_c%0d", c + 1), cd_pos_x[3:0], (c + 3) / 4);
      chk($sformatf("cd_y_c%0d", c + 1), cd_pos_y[3:0], 0);
      chk($sformatf("cd_face_c%0d", c + 1), cd_face[1:0],
          (c + 1 < 2) ? 0 : ((c + 1 == 4) ? 1 : 3));
      chk($sformatf("cd_moved_c%0d", c + 1), cd_moved[0], ((c + 1) % 4 == 2) ? 1 : 0);
    end
    drv(2'b00, 3'd4, 3'd4, 2'b00);

    // Mid-operation reset with a bomb pending at (2,2)
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drv(2'b01, (c < 2) ? 3'd3 : ((c < 4) ? 3'd1 : 3'd4), 3'd4, (c == 4) ? 2'b01 : 2'b00);
      tick();
    end
    drv(2'b00, 3'd4, 3'd4, 2'b00);
    tick();
    chk("mr_pos", coord[7:0], 32'h22);
    tick(3);
    chk("mr_commit_pre", commit, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_p0", coord[7:0], 0);
    chk("mr_p1", coord[15:8], 32'hff);
    chk("mr_face", face, 0);
    chk("mr_commit", commit, 0);
    chk("mr_setb", set_bomb, 0);
    chk("mr_moved", moved, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("mr_nobomb_c%0d", c + 1), set_bomb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_player_controller.md
# multi_player_controller

Parametrised player-movement and bomb-placement controller for N players on a 2^GW × 2^GW grid. It sits between the per-player input decoders and the bomb/explosion manager. It owns player positions, facing and per-player move cooldown. It resolves collisions against walls, grid edges and other players, then publishes accepted bomb placements on a periodic commit strobe.

## Interface
- NUM_PLAYERS, 2: player count, 2..4.
- GW, 4: grid coordinate width; grid is 2^GW × 2^GW, CELLS = 2^(2·GW).
- BW, 3: bomb counter width.
- STEP_INTERVAL, 0: idle cycles forced after each accepted move; 0 = no cooldown.
- COMMIT_PERIOD, 5: commit strobe period in cycles, ≥2.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid_i  in  N  per-player request strobe.
- dir_i  in  3·N  per-player direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 STOP; 5..7 treated as STOP.
- bomb_req_i  in  N  per-player bomb request; qualified by in_valid_i.
- alive_i  in  N  player alive flag.
- wall_i  in  CELLS  1 = cell blocked; index = y·2^GW + x.
- bomb_num_i  in  BW·N  bombs currently live per player.
- bomb_max_i  in  BW·N  bomb capacity per player.
- pos_x_o, pos_y_o  out  GW·N  registered position.
- coord_o  out  2·GW·N  {y,x} linear cell index.
- face_o  out  2·N  last non-STOP direction.
- moved_o  out  N  one-cycle pulse on accepted move.
- commit_o  out  1  commit strobe.
- set_bomb_o  out  N  one-cycle bomb placement pulse.
- bomb_coord_o  out  2·GW·N  cell of published bomb; held until next publish.

## Operation
- Capture stage:
  - On an edge with in_valid_i[i]=1, dir_i/bomb_req_i for player i are registered with a valid flag.
  - Inputs are not used after capture.
  - The flag self-clears after one cycle; a new strobe while it is set overwrites it.
- Decision stage, in cycles where the captured flag is set and alive_i[i]=1:
  - **Face:** updates to any non-STOP direction, even if the move is rejected or the player is in cooldown.
  - **Move acceptance:** requires cooldown=0, a non-STOP direction, and a valid target.
  - **Target rejection:** the target is rejected if it is off-grid (no wrap), wall_i=1, equal to another player's current position, or equal to the accepted target of a lower-index player in the same cycle. Lower index wins.
  - **On acceptance:** position updates, moved_o pulses, and the cooldown counter loads STEP_INTERVAL.
  - **Bomb acceptance:** accepted iff pending[i]=0 and bomb_num_i[i] < bomb_max_i[i] (unsigned). The bomb cell is the pre-move position; pending[i] sets.
- Cooldown counter: decrements to 0, one per cycle, independent of requests.
- Commit counter: cnt runs 0..COMMIT_PERIOD-1 and wraps; commit_o = (cnt == COMMIT_PERIOD-1).
- Publish on the edge leaving cnt=COMMIT_PERIOD-1:
  - For each pending player: set_bomb_o[i]=1 for exactly one cycle, bomb_coord_o loads the latched cell, and pending clears.
  - A bomb request decided on that same edge sees pending=1 and is rejected.
- alive_i[i]=0: requests are ignored, position frozen, and pending[i] cleared without publish.

## Timing
- Reset values:
  - Positions: P0 (0,0); P1 (max,max); P2 (max,0); P3 (0,max), where max = 2^GW−1.
  - face_o=0 (UP); moved_o=0; set_bomb_o=0; bomb_coord_o=0; commit_o=0; cnt=0; cooldowns=0; pending=0; captured flags=0.
- Latency: in_valid_i high in cycle t is captured at the end of t and decided in t+1. pos/face/moved_o are visible in t+2.
- Request throughput: one per player every cycle.
- First commit_o occurs in cycle COMMIT_PERIOD-1 after reset release. set_bomb_o is high in the following cycle.
- Reset assertion mid-operation returns all state to reset values immediately. Pending bombs are discarded.

## Test plan
- **Free move:** N=2, no walls; P0 RIGHT strobe at t=0 → pos_x_o[0]=1 in cycle 2, moved_o[0] pulses in cycle 2, face_o[0]=3.
- **Edge block:** P0 at (0,0) requests UP then LEFT → position unchanged, face_o[0]=0 then 2, moved_o stays 0.
- **Same-cycle contention:** N=2, P0 at (3,4) RIGHT and P1 at (5,4) LEFT in the same cycle → P0 moves to (4,4); P1 stays at (5,4) with face 2.
- **Bomb gating:** bomb_max=2, bomb_num=1, P0 bomb at (0,0) → single set_bomb_o[0] pulse after the next commit_o with bomb_coord_o[0]=0. A second request before that publish, or with bomb_num=2, yields no pulse.
- **Cooldown:** STEP_INTERVAL=3, P0 RIGHT strobed every cycle → x advances every 4 cycles; face updates every cycle.
- **Mid-op reset:** P0 at (2,2) with a bomb pending; assert rst low → outputs return to reset values asynchronously, and no set_bomb_o pulse occurs after release.
